// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter in front of the UART tx FIFO write port.
// Optional idle-requester timeout is enabled by defining UART_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no owner; pick the next requester after ptr, register it into grant
// SEND  | grant held; forward bytes of the owner until its last byte (or timeout)
module uart_tx_arbiter #(
  parameter int NREQ   = 4,
  parameter int DBIT   = 8,
  parameter int TO_CYC = 1024,
  parameter int TO_BIT = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      last,
  input  logic [NREQ*DBIT-1:0] data,
  output logic [NREQ-1:0]      ack,
  input  logic                 tx_full,
  output logic                 wr_uart,
  output logic [DBIT-1:0]      w_data,
  output logic [NREQ-1:0]      grant,
  output logic                 busy,
  output logic [NREQ-1:0]      abort
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] g_idx;
  logic [PW-1:0] cand;
  logic [PW-1:0] win_idx;
  logic          win_vld;
  logic          g_req;
  logic          g_last;
  logic          to_hit;

  // Search order starts just after the last served requester.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = PW'((int'(ptr) + k) % NREQ);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign g_req   = req[g_idx];
  assign g_last  = last[g_idx];
  assign busy    = (state == SEND);
  assign wr_uart = busy & g_req & ~tx_full;
  assign w_data  = busy ? data[int'(g_idx)*DBIT +: DBIT] : '0;
  assign ack     = wr_uart ? grant : '0;

`ifdef UART_ARB_TIMEOUT_EN
  logic [TO_BIT-1:0] to_cnt;

  // Only owner inactivity counts; a stall on tx_full with req held is not idle time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt <= '0;
    end else if (state == IDLE || wr_uart) begin
      to_cnt <= '0;
    end else if (!g_req) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign to_hit = busy & ~g_req & (to_cnt == TO_BIT'(TO_CYC - 1));
  assign abort  = to_hit ? grant : '0;
`else
  assign to_hit = 1'b0;
  assign abort  = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr   <= PW'(NREQ - 1);
      g_idx <= '0;
      grant <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            g_idx <= win_idx;
            grant <= NREQ'(1) << win_idx;
            state <= SEND;
          end
        end
        SEND: begin
          if ((wr_uart && g_last) || to_hit) begin
            ptr   <= g_idx;
            grant <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
